delay_tap_reader: RTL and testbench

- Read-side engine for a circular BRAM delay buffer.
- A separate writer stores one sample per sample period and publishes its write index. On each sample tick this block reads NTAPS taps at programmable delays behind that index.
- Taps are returned serially over a valid/ready stream. Feeds multi-tap reverb/echo mixers.
- BRAM read port has 1-cycle latency.

---
 rtl/delay_pkg.sv | 21 ++
 rtl/delay_addr_calc.sv | 67 ++++++
 rtl/delay_tap_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_delay_tap_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// ---------------------------------------------------------------------------
// delay_pkg
//   Shared types and helpers for the delay-buffer tap reader.
//   - tap_state_t : sequencing states of the tap reader
//   - clog2_min1  : width helper that never returns 0, so a single-tap build
//                   still gets a 1-bit tap index
// ---------------------------------------------------------------------------
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } tap_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_addr_calc.sv
// ---------------------------------------------------------------------------
// delay_addr_calc
//   Purely combinational address generator for a circular delay buffer.
//   Clamps the active length into 1..MAXLEN, clamps the delay to the window,
//   and returns the buffer index that lies 'delay' samples behind widx.
//
//   Ports:
//     widx    in   ADDR_W    index of the most recently written sample
//     len     in   32        requested window length (0 or >MAXLEN -> MAXLEN)
//     delay   in   ADDR_W    requested delay in samples
//     len_eff out  ADDR_W+1  clamped window length
//     d_eff   out  ADDR_W    clamped delay (only with DELAY_TAP_ZERO_FILL_EN)
//     addr    out  ADDR_W    read index inside the window
//
//   Config macro: DELAY_TAP_ZERO_FILL_EN exposes d_eff for the zero-fill path.
// ---------------------------------------------------------------------------
module delay_addr_calc
  import delay_pkg::*;
#(
  parameter int MAXLEN = 2048,
  localparam int ADDR_W = $clog2(MAXLEN)
) (
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       len,
  input  logic [ADDR_W-1:0] delay,
  output logic [ADDR_W:0]   len_eff,
`ifdef DELAY_TAP_ZERO_FILL_EN
  output logic [ADDR_W-1:0] d_eff,
`endif
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0] MAX_EFF = (ADDR_W+1)'(MAXLEN);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [ADDR_W:0] lim;
  logic [ADDR_W:0] d_ext;
  logic [ADDR_W:0] sum;

  // Adding len_eff before subtracting the delay keeps the intermediate
  // non-negative, so one conditional subtract folds it back into the window.
  always_comb begin
    if (len == 32'd0 || len > 32'(MAXLEN)) begin
      len_eff = MAX_EFF;
    end else begin
      len_eff = len[ADDR_W:0];
    end

    lim   = len_eff - ONE;
    d_ext = {1'b0, delay};
    if (d_ext > lim) begin
      d_ext = lim;
    end

    sum = {1'b0, widx} + len_eff - d_ext;
    if (sum >= len_eff) begin
      sum = sum - len_eff;
    end
    addr = sum[ADDR_W-1:0];
  end

`ifdef DELAY_TAP_ZERO_FILL_EN
  // lim never exceeds MAXLEN-1, so the top bit of the clamped delay is zero.
  assign d_eff = d_ext[ADDR_W-1:0];
`endif

endmodule

// File: rtl/delay_tap_reader.sv
// ---------------------------------------------------------------------------
// delay_tap_reader
//   Read-side engine for a circular BRAM delay buffer. On every accepted
//   sample_tick it latches the writer index, window length and tap delays,
//   then reads NTAPS taps one at a time and streams them out over a
//   valid/ready interface. The BRAM read port has one cycle of latency.
//
//   Ports:
//     clk          in   1              system clock
//     rst          in   1              synchronous active-high reset
//     sample_tick  in   1              starts a read sequence
//     widx         in   ADDR_W         writer's most recently written index
//     len          in   32             active buffer length in samples
//     tap_delay    in   NTAPS*ADDR_W   packed per-tap delays
//     mem_rd_addr  out  ADDR_W         BRAM read address
//     mem_rd_data  in   WIDTH          BRAM read data (1 cycle after address)
//     out_data     out  WIDTH          tap sample
//     out_tap      out  TAP_W          tap index of out_data
//     out_valid    out  1              out_data/out_tap valid
//     out_ready    in   1              consumer accept
//     busy         out  1              sequence in progress
//     overrun      out  1              sticky: tick arrived while busy
//
//   Config macro: DELAY_TAP_ZERO_FILL_EN
//     Defined: taps whose delay reaches beyond the samples written so far
//     (fill <= d_eff) return 0 instead of stale BRAM contents.
//     Undefined: out_data is always the BRAM data; no fill counter is built.
// ---------------------------------------------------------------------------
module delay_tap_reader
  import delay_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MAXLEN = 2048,
  parameter int NTAPS  = 4,
  localparam int ADDR_W = $clog2(MAXLEN),
  localparam int TAP_W  = clog2_min1(NTAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic [ADDR_W-1:0]       widx,
  input  logic [31:0]             len,
  input  logic [NTAPS*ADDR_W-1:0] tap_delay,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [WIDTH-1:0]        mem_rd_data,
  output logic [WIDTH-1:0]        out_data,
  output logic [TAP_W-1:0]        out_tap,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  tap_state_t state, state_nxt;

  logic [TAP_W-1:0]        tap;
  logic [TAP_W-1:0]        tap_sel;
  logic                    last_tap;
  logic                    accept;
  logic                    handshake;
  logic                    load_addr;

  logic [ADDR_W-1:0]       widx_l;
  logic [ADDR_W:0]         len_eff_l;
  logic [NTAPS*ADDR_W-1:0] delay_l;

  logic [ADDR_W-1:0]       calc_widx;
  logic [31:0]             calc_len;
  logic [ADDR_W-1:0]       calc_delay;
  logic [ADDR_W:0]         calc_len_eff;
  logic [ADDR_W-1:0]       calc_addr;

`ifdef DELAY_TAP_ZERO_FILL_EN
  logic [ADDR_W-1:0]       calc_d_eff;
  logic [ADDR_W-1:0]       d_eff_q;
  logic [ADDR_W:0]         fill_cnt;
  logic [ADDR_W:0]         fill_l;
  logic                    zero_out;
`endif

  assign last_tap = (tap == LAST_TAP);

  // The address register is loaded on the edge that enters ISSUE, so the
  // calculator looks one step ahead: live inputs for tap 0 while idle,
  // latched values and the following tap's delay otherwise.
  always_comb begin
    tap_sel = last_tap ? tap : tap + TAP_W'(1);
    if (state == IDLE) begin
      calc_widx  = widx;
      calc_len   = len;
      calc_delay = tap_delay[ADDR_W-1:0];
    end else begin
      calc_widx  = widx_l;
      calc_len   = {{(31-ADDR_W){1'b0}}, len_eff_l};
      calc_delay = delay_l[int'(tap_sel)*ADDR_W +: ADDR_W];
    end
  end

  delay_addr_calc #(
    .MAXLEN(MAXLEN)
  ) u_addr_calc (
    .widx    (calc_widx),
    .len     (calc_len),
    .delay   (calc_delay),
    .len_eff (calc_len_eff),
`ifdef DELAY_TAP_ZERO_FILL_EN
    .d_eff   (calc_d_eff),
`endif
    .addr    (calc_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the one-cycle strobes the datapath acts on.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = last_tap ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_addr = accept | (handshake & ~last_tap);

`ifdef DELAY_TAP_ZERO_FILL_EN
  assign zero_out = (fill_l <= {1'b0, d_eff_q});
`endif

  // Sequence datapath: latches, address, output register and status flags.
  // A tick outside IDLE (including one coinciding with the final handshake)
  // is dropped and only recorded in overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx_l      <= '0;
      len_eff_l   <= '0;
      delay_l     <= '0;
      tap         <= '0;
      mem_rd_addr <= '0;
      out_data    <= '0;
      out_tap     <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (accept) begin
        widx_l    <= widx;
        len_eff_l <= calc_len_eff;
        delay_l   <= tap_delay;
        tap       <= '0;
        busy      <= 1'b1;
      end

      if (load_addr) begin
        mem_rd_addr <= calc_addr;
      end

      if (state == WAIT) begin
`ifdef DELAY_TAP_ZERO_FILL_EN
        out_data <= zero_out ? '0 : mem_rd_data;
`else
        out_data <= mem_rd_data;
`endif
        out_tap   <= tap;
        out_valid <= 1'b1;
      end

      if (handshake) begin
        out_valid <= 1'b0;
        if (last_tap) begin
          busy <= 1'b0;
        end else begin
          tap <= tap + TAP_W'(1);
        end
      end

      if (sample_tick && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef DELAY_TAP_ZERO_FILL_EN
  // fill_l snapshots the count of earlier ticks, so the first sequence after
  // reset sees fill 0 and every tap is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      fill_l   <= '0;
      d_eff_q  <= '0;
    end else begin
      if (accept) begin
        fill_l <= fill_cnt;
        if (fill_cnt != (ADDR_W+1)'(MAXLEN)) begin
          fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
        end
      end
      if (load_addr) begin
        d_eff_q <= calc_d_eff;
      end
    end
  end
`endif

endmodule

// File: tb/tb_delay_tap_reader.sv
// ---------------------------------------------------------------------------
// tb_delay_tap_reader
//   Self-checking bench for delay_tap_reader. A behavioural model turns each
//   accepted tick into a list of expected (tap, data) pairs using modular
//   arithmetic on the bench's own BRAM image, and tracks busy/valid/overrun.
// ---------------------------------------------------------------------------
module tb_delay_tap_reader;

  localparam int WIDTH  = 32;
  localparam int MAXLEN = 2048;
  localparam int NTAPS  = 4;
  localparam int ADDR_W = 11;
  localparam int TAP_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    sample_tick;
  logic [ADDR_W-1:0]       widx;
  logic [31:0]             len;
  logic [NTAPS*ADDR_W-1:0] tap_delay;
  logic [ADDR_W-1:0]       mem_rd_addr;
  logic [WIDTH-1:0]        mem_rd_data;
  logic [WIDTH-1:0]        out_data;
  logic [TAP_W-1:0]        out_tap;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    overrun;

  delay_tap_reader #(
    .WIDTH (WIDTH),
    .MAXLEN(MAXLEN),
    .NTAPS (NTAPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .widx       (widx),
    .len        (len),
    .tap_delay  (tap_delay),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_data   (out_data),
    .out_tap    (out_tap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // BRAM image with a registered read port.
  logic [WIDTH-1:0] mem [MAXLEN];
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [31:0] data;
    int          tap;
  } exp_t;

  exp_t expq[$];
  int   pending;
  int   wait_ctr;
  logic exp_overrun;
  int   fill_m;
  int   vec_count;
  int   err_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vec_count++;
    if (got !== expv) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [NTAPS*ADDR_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NTAPS*ADDR_W-1:0] v;
    v = {ADDR_W'(d), ADDR_W'(c), ADDR_W'(b), ADDR_W'(a)};
    return v;
  endfunction

  // Reference: a tap at delay d reads the sample d positions behind widx,
  // wrapping inside a window of len_eff samples.
  task automatic push_expect();
    int le, d, de, a;
    logic [31:0] v;
    int fill_before;
    le = (len == 32'd0 || len > 32'(MAXLEN)) ? MAXLEN : int'(len);
    fill_before = fill_m;
    for (int t = 0; t < NTAPS; t++) begin
      d  = int'(tap_delay[t*ADDR_W +: ADDR_W]);
      de = (d < le - 1) ? d : le - 1;
      a  = ((int'(widx) - de) % le + le) % le;
      v  = mem[a];
`ifdef DELAY_TAP_ZERO_FILL_EN
      if (fill_before <= de) v = 32'd0;
`endif
      expq.push_back('{v, t});
    end
    fill_m = (fill_m + 1 > MAXLEN) ? MAXLEN : fill_m + 1;
  endtask

  // One clock: check streamed data against the model before the edge, then
  // advance the model and check status flags #1 after the edge.
  task automatic cycle();
    logic acc, hs;
    acc = sample_tick && pending == 0 && !rst;
    if (sample_tick && pending != 0 && !rst) exp_overrun = 1'b1;
    hs = out_valid && out_ready && !rst;
    if (out_valid) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("tap_idx", 32'(out_tap), 32'(expq[0].tap));
        checkOutput("tap_data", out_data, expq[0].data);
      end
    end
    if (acc) push_expect();
    if (hs && expq.size() != 0) void'(expq.pop_front());
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    if (rst) begin
      expq.delete();
      pending     = 0;
      wait_ctr    = 0;
      exp_overrun = 1'b0;
      fill_m      = 0;
    end else if (acc) begin
      pending  = NTAPS;
      wait_ctr = 2;
    end else if (hs && pending > 0) begin
      pending--;
      wait_ctr = (pending > 0) ? 2 : 0;
    end else if (wait_ctr > 0) begin
      wait_ctr--;
    end
    checkOutput("busy", 32'(busy), 32'(pending != 0));
    checkOutput("out_valid", 32'(out_valid), 32'(pending > 0 && wait_ctr == 0));
    checkOutput("overrun", 32'(overrun), 32'(exp_overrun));
  endtask

  task automatic checkReset();
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_tap", 32'(out_tap), 32'd0);
    checkOutput("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
  endtask

  task automatic applyStimulus(input int w, input logic [31:0] l, input logic [NTAPS*ADDR_W-1:0] dly);
    widx        = ADDR_W'(w);
    len         = l;
    tap_delay   = dly;
    sample_tick = 1'b1;
    cycle();
  endtask

  // mode 0: ready always high; mode 1: random ready, scrambled inputs and
  // occasional ticks while busy.
  task automatic run_until_idle(input int budget, input int mode);
    int n;
    n = 0;
    while (pending != 0) begin
      if (n >= budget) begin
        checkOutput("idle_timeout", 32'd1, 32'd0);
        break;
      end
      if (mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          widx      = ADDR_W'($urandom);
          len       = $urandom;
          tap_delay = {$urandom, $urandom};
        end
        if ($urandom_range(0, 15) == 0) sample_tick = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      cycle();
      n++;
    end
  endtask

  task automatic wait_for_tap(input int t, input logic ready_val);
    int n;
    n = 0;
    while (!(out_valid && int'(out_tap) == t)) begin
      if (n >= 40) begin
        checkOutput("tap_wait_timeout", 32'd1, 32'd0);
        break;
      end
      out_ready = ready_val;
      cycle();
      n++;
    end
  endtask

  initial begin
    int le;
    logic [NTAPS*ADDR_W-1:0] dly;

    vec_count   = 0;
    err_count   = 0;
    expq.delete();
    pending     = 0;
    wait_ctr    = 0;
    exp_overrun = 1'b0;
    fill_m      = 0;

    rst         = 1'b1;
    sample_tick = 1'b0;
    widx        = '0;
    len         = '0;
    tap_delay   = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < MAXLEN; i++) mem[i] = 32'(i);
    cycle();
    checkReset();
    rst = 1'b0;
    cycle();

    $display("[TB] basic read");
    out_ready = 1'b1;
    applyStimulus(10, 32'd16, pack4(0, 3, 10, 15));
    run_until_idle(100, 0);

    $display("[TB] clamps");
    applyStimulus(2, 32'd16, pack4(40, 15, 16, 1));
    run_until_idle(100, 0);
    applyStimulus(2, 32'd0, pack4(5, 0, 2047, 3));
    run_until_idle(100, 0);
    applyStimulus(100, 32'd5000, pack4(101, 2047, 7, 100));
    run_until_idle(100, 0);

    $display("[TB] backpressure");
    out_ready = 1'b1;
    applyStimulus(5, 32'd32, pack4(1, 2, 3, 4));
    wait_for_tap(1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b0;
      cycle();
    end
    run_until_idle(100, 0);

    $display("[TB] tick on final handshake");
    out_ready = 1'b1;
    applyStimulus(3, 32'd20, pack4(0, 19, 4, 8));
    wait_for_tap(3, 1'b1);
    out_ready   = 1'b1;
    sample_tick = 1'b1;
    cycle();
    run_until_idle(100, 0);
    cycle();

    $display("[TB] overrun");
    applyStimulus(7, 32'd64, pack4(2, 9, 30, 63));
    cycle();
    applyStimulus(50, 32'd8, pack4(1, 1, 1, 1));
    run_until_idle(100, 0);
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] reset mid-sequence");
    out_ready = 1'b1;
    applyStimulus(12, 32'd100, pack4(0, 5, 50, 99));
    wait_for_tap(2, 1'b1);
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    checkReset();
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(40, 32'd128, pack4(3, 41, 127, 0));
    run_until_idle(100, 0);

`ifdef DELAY_TAP_ZERO_FILL_EN
    $display("[TB] zero fill");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < MAXLEN; i++) mem[i] = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 32'd16, pack4(0, 1, 2, 3));
      run_until_idle(100, 0);
    end
`endif

    $display("[TB] randomized sequences");
    for (int it = 0; it < 60; it++) begin
      if (it % 10 == 0) begin
        for (int i = 0; i < MAXLEN; i++) mem[i] = $urandom;
      end
      case ($urandom_range(0, 4))
        0:       len = 32'd0;
        1:       len = 32'($urandom_range(MAXLEN + 1, 100000));
        2:       len = 32'(MAXLEN);
        3:       len = 32'($urandom_range(1, 40));
        default: len = 32'($urandom_range(1, MAXLEN));
      endcase
      le = (len == 32'd0 || len > 32'(MAXLEN)) ? MAXLEN : int'(len);
      for (int t = 0; t < NTAPS; t++) begin
        if ($urandom_range(0, 1) == 0) dly[t*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, MAXLEN - 1));
        else                           dly[t*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, le));
      end
      out_ready = ($urandom_range(0, 1) != 0);
      applyStimulus($urandom_range(0, le - 1), len, dly);
      run_until_idle(400, 1);
      if ($urandom_range(0, 2) == 0) cycle();
    end

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
